// File: rtl/uart_rx_sipo_if.sv
// Receiver-side bundle: the serial line, the frame format controls and the
// received data/status. The master drives the line and the controls; the slave
// (the receiver) returns the data and status.
interface uart_rx_sipo_if;
    logic       sample_tick;
    logic       rx_in;
    logic       data_length;
    logic [1:0] parity_type;
    logic       stop_bits;
    logic [7:0] data_out;
    logic       rx_done;
    logic       parity_error;
    logic       framing_error;
    logic       rx_active;

    modport master (
        output sample_tick, rx_in, data_length, parity_type, stop_bits,
        input  data_out, rx_done, parity_error, framing_error, rx_active
    );

    modport slave (
        input  sample_tick, rx_in, data_length, parity_type, stop_bits,
        output data_out, rx_done, parity_error, framing_error, rx_active
    );
endinterface

// File: rtl/uart_rx_sipo.sv
// Oversampling serial-in/parallel-out UART receiver. Finds the start bit,
// samples every following bit at its centre, checks parity and stop bits and
// presents the byte with its status on a one-clock rx_done pulse.
module uart_rx_sipo #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_sipo_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BREAK
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [TW-1:0]          r_tick;
    logic [2:0]             r_bit;
    logic [7:0]             r_shift;
    logic                   r_xor;
    logic                   r_len;
    logic [1:0]             r_ptype;
    logic                   r_stop2;
    logic                   r_perr_f;
    logic                   r_ferr_f;
    logic [7:0]             r_data_out;
    logic                   r_rx_done;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_rx_active;

    logic w_rx_s;
    logic w_tick;
    logic w_par_en;
    logic w_sample;

    assign w_rx_s   = r_sync[SYNC_STAGES-1];
    assign w_tick   = bus.sample_tick;
    // Parity bit is present only for 01 (odd) and 10 (even).
    assign w_par_en = r_ptype[0] ^ r_ptype[1];
    // Data, parity and stop bits are sampled one full bit after the previous centre.
    assign w_sample = w_tick && (r_tick == TICK_LAST);

    // Metastability synchroniser; idles high like the line itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.rx_in};
        end
    end

    // Frame FSM with bit/tick counters and registered data/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_xor       <= 1'b0;
            r_len       <= 1'b0;
            r_ptype     <= 2'b00;
            r_stop2     <= 1'b0;
            r_perr_f    <= 1'b0;
            r_ferr_f    <= 1'b0;
            r_data_out  <= '0;
            r_rx_done   <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_rx_active <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Format controls are captured here and frozen for the frame.
                    r_len   <= bus.data_length;
                    r_ptype <= bus.parity_type;
                    r_stop2 <= bus.stop_bits;
                    if (w_tick && !w_rx_s) begin
                        r_state     <= ST_START;
                        r_tick      <= '0;
                        r_xor       <= 1'b0;
                        r_perr_f    <= 1'b0;
                        r_ferr_f    <= 1'b0;
                        r_rx_active <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        if (r_tick == TICK_HALF) begin
                            if (w_rx_s) begin
                                // Line went back high before mid-bit: a glitch.
                                r_state     <= ST_IDLE;
                                r_rx_active <= 1'b0;
                            end else begin
                                r_state <= ST_DATA;
                                r_tick  <= '0;
                                r_bit   <= '0;
                            end
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                end

                ST_DATA: begin
                    if (w_sample) begin
                        r_tick  <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_xor   <= r_xor ^ w_rx_s;
                        if (r_bit == (r_len ? 3'd7 : 3'd6)) begin
                            r_state <= w_par_en ? ST_PARITY : ST_STOP1;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else if (w_tick) begin
                        r_tick <= r_tick + TW'(1);
                    end
                end

                ST_PARITY: begin
                    if (w_sample) begin
                        r_tick   <= '0;
                        // Odd: data ^ parity must be 1; even: must be 0.
                        r_perr_f <= (r_ptype == 2'b01) ? ~(r_xor ^ w_rx_s) : (r_xor ^ w_rx_s);
                        r_state  <= ST_STOP1;
                    end else if (w_tick) begin
                        r_tick <= r_tick + TW'(1);
                    end
                end

                ST_STOP1, ST_STOP2: begin
                    if (w_sample) begin
                        r_tick <= '0;
                        if (r_state == ST_STOP1 && r_stop2) begin
                            r_ferr_f <= r_ferr_f | ~w_rx_s;
                            r_state  <= ST_STOP2;
                        end else begin
                            // Final stop bit: publish the frame.
                            r_rx_done   <= 1'b1;
                            r_data_out  <= r_len ? r_shift : {1'b0, r_shift[7:1]};
                            r_perr      <= r_perr_f;
                            r_ferr      <= r_ferr_f | ~w_rx_s;
                            r_state     <= w_rx_s ? ST_IDLE : ST_BREAK;
                            r_rx_active <= ~w_rx_s;
                        end
                    end else if (w_tick) begin
                        r_tick <= r_tick + TW'(1);
                    end
                end

                ST_BREAK: begin
                    // Hold off until the line returns high so a stuck-low line
                    // cannot start a new frame.
                    if (w_tick && w_rx_s) begin
                        r_state     <= ST_IDLE;
                        r_rx_active <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_rx_active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out      = r_data_out;
    assign bus.rx_done       = r_rx_done;
    assign bus.parity_error  = r_perr;
    assign bus.framing_error = r_ferr;
    assign bus.rx_active     = r_rx_active;
endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for the UART receiver: frames are driven bit by bit, the
// expected byte/status is queued when a frame is issued, and a monitor pops
// and compares on every rx_done.
module tb_uart_rx_sipo;
    logic clk;
    logic rst;

    uart_rx_sipo_if bus ();

    uart_rx_sipo #(
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_pushed = 0;
    int   tcnt     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sample_tick every 4th clock, driven away from the active edge.
    initial begin
        bus.sample_tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt = tcnt + 1;
            bus.sample_tick = (tcnt % 4 == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rx_done is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.rx_done === 1'b1) begin
            exp_t e;
            n_done++;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rx_done: got data %h expected no frame", bus.data_out);
            end else begin
                e = q.pop_front();
                $display("rx frame: data=%h pe=%b fe=%b (expected %h %b %b)",
                         bus.data_out, bus.parity_error, bus.framing_error, e.d, e.pe, e.fe);
                chk("data_out", {24'd0, bus.data_out}, {24'd0, e.d});
                chk("parity_error", {31'd0, bus.parity_error}, {31'd0, e.pe});
                chk("framing_error", {31'd0, bus.framing_error}, {31'd0, e.fe});
            end
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        q.push_back(e);
        n_pushed++;
    endtask

    task automatic set_cfg(input logic len, input logic [1:0] pt, input logic sb);
        bus.data_length = len;
        bus.parity_type = pt;
        bus.stop_bits   = sb;
    endtask

    task automatic send_bit(input logic v);
        bus.rx_in = v;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic has_par,
                              input logic pbit, input logic s1, input logic has_s2,
                              input logic s2);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (has_par) send_bit(pbit);
        send_bit(s1);
        if (has_s2) send_bit(s2);
    endtask

    // Bounded wait for the monitor to consume every queued frame.
    task automatic drain(input string name);
        int k;
        k = 0;
        while (q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(name, q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        rst     = 1'b1;
        bus.rx_in = 1'b1;
        set_cfg(1'b1, 2'b00, 1'b0);

        // 1. Reset state.
        repeat (3) @(negedge clk);
        chk("rst_data_out", {24'd0, bus.data_out}, 32'd0);
        chk("rst_rx_done", {31'd0, bus.rx_done}, 32'd0);
        chk("rst_parity_error", {31'd0, bus.parity_error}, 32'd0);
        chk("rst_framing_error", {31'd0, bus.framing_error}, 32'd0);
        chk("rst_rx_active", {31'd0, bus.rx_active}, 32'd0);
        rst = 1'b0;
        repeat (128) @(negedge clk);

        // 2. 8N1 0xA5.
        set_cfg(1'b1, 2'b00, 1'b0);
        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1);
        drain("drain_8n1");
        chk("idle_after_8n1", {31'd0, bus.rx_active}, 32'd0);

        // 3. 8-odd-1, 0x96 has four ones: parity 0 is wrong, parity 1 is right.
        set_cfg(1'b1, 2'b01, 1'b0);
        push_exp(8'h96, 1'b1, 1'b0);
        send_frame(8'h96, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1);
        drain("drain_odd_bad");
        push_exp(8'h96, 1'b0, 1'b0);
        send_frame(8'h96, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1);
        drain("drain_odd_good");

        // 4. 7-even-2, 0x41 has two ones so even parity bit 0; second stop low.
        set_cfg(1'b0, 2'b10, 1'b1);
        push_exp(8'h41, 1'b0, 1'b1);
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (128) @(negedge clk);
        drain("drain_7e2");
        chk("break_held_active", {31'd0, bus.rx_active}, 32'd1);
        bus.rx_in = 1'b1;
        repeat (64) @(negedge clk);
        chk("break_released", {31'd0, bus.rx_active}, 32'd0);

        // 5. Two-tick glitch on an idle line.
        set_cfg(1'b1, 2'b00, 1'b0);
        saw = 1'b0;
        bus.rx_in = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rx_active === 1'b1) saw = 1'b1;
        end
        bus.rx_in = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (bus.rx_active === 1'b1) saw = 1'b1;
        end
        chk("glitch_active_seen", {31'd0, saw}, 32'd1);
        chk("glitch_back_idle", {31'd0, bus.rx_active}, 32'd0);
        chk("glitch_data_kept", {24'd0, bus.data_out}, 32'h41);

        // 6. Reset during bit 4 of 0x3C, then a clean 0x5A.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(8'h3C >> i);
        bus.rx_in = 1'b1;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midframe_rst_data", {24'd0, bus.data_out}, 32'd0);
        chk("midframe_rst_active", {31'd0, bus.rx_active}, 32'd0);
        rst = 1'b0;
        repeat (128) @(negedge clk);
        push_exp(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1);
        drain("drain_after_rst");

        chk("total_rx_done", n_done, n_pushed);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
